bin2bcd: RTL

Sequential binary-to-BCD converter: accepts a 7-bit unsigned binary value on a `start` pulse and produces its three-digit BCD equivalent (hundreds, tens, units) using the shift-and-add-3 (double-dabble) algorithm, one bit per cycle. It is the inverse of the bcd2bin target and uses the same handshake: `start`, `ready`, `done_tick`. It sits as a user-logic target behind the FPGA fabric and is driven by a per-target test module.

---
 rtl/bin2bcd.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bin2bcd.sv
// Converts a 7-bit unsigned binary value to three BCD digits by shift-and-add-3, one bit per cycle.
// Latency: done_tick is high 8 cycles after the edge that samples start; a new start is accepted every 9 cycles at best.
// Backpressure: start is accepted only while ready is high; a start seen while busy is dropped, not queued.
module bin2bcd (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       ready,
  output logic       done_tick,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;

  // operand bits still to be shifted into the digit registers, MSB first
  logic [6:0] p;
  // shifts remaining in the current conversion
  logic [2:0] n;

  // digits after the add-3 correction, ahead of this cycle's shift
  logic [3:0] adj1;
  logic [3:0] adj0;
  // the hundreds digit never exceeds 1 for a 7-bit operand, so only its low
  // three bits survive the shift; bit 3 is still looked at in the compare
  logic [2:0] adj2_lo;

  // state register; synchronous reset abandons any conversion in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state decode: IDLE waits for start, OP runs seven shifts, DONE lasts one cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = OP;
        end
      end
      OP: begin
        if (n == 3'd1) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // handshake outputs are decoded from state alone, so no input reaches an output combinationally
  always_comb begin
    ready     = 1'b0;
    done_tick = 1'b0;
    case (state)
      IDLE:    ready     = 1'b1;
      DONE:    done_tick = 1'b1;
      default: begin
        ready     = 1'b0;
        done_tick = 1'b0;
      end
    endcase
  end

  // add-3 correction: any digit of 5 or more is bumped so the coming doubling carries into the next digit
  always_comb begin
    adj0    = (bcd0 > 4'd4) ? bcd0 + 4'd3 : bcd0;
    adj1    = (bcd1 > 4'd4) ? bcd1 + 4'd3 : bcd1;
    adj2_lo = (bcd2 > 4'd4) ? bcd2[2:0] + 3'd3 : bcd2[2:0];
  end

  // datapath: load on accepted start, shift {digits, p} left once per OP cycle, hold otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      p    <= 7'd0;
      n    <= 3'd0;
      bcd2 <= 4'd0;
      bcd1 <= 4'd0;
      bcd0 <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            p    <= bin;
            n    <= 3'd7;
            bcd2 <= 4'd0;
            bcd1 <= 4'd0;
            bcd0 <= 4'd0;
          end
        end
        OP: begin
          bcd2 <= {adj2_lo, adj1[3]};
          bcd1 <= {adj1[2:0], adj0[3]};
          bcd0 <= {adj0[2:0], p[6]};
          p    <= {p[5:0], 1'b0};
          n    <= n - 3'd1;
        end
        default: begin
          // DONE: results stay put until the next accepted start
        end
      endcase
    end
  end

endmodule
